gemv_tile_seq: RTL and testbench
================================

# gemv_tile_seq

K-tiling sequencer that sits above the single-tile PE controller and drives the other side of its buffers and handshake. It accepts a job command (number of K-tiles), then for each tile writes a weight tile and an input vector into the weight and input BRAMs (Port A). It starts the PE controller with `clear_acc` asserted only on the first tile and waits for its `done`. After the last tile it reads the output BRAM (Port B, 2-cycle latency) and returns the accumulated vector on a valid/ready result port.

## Interface
- SUBARRAY_ROWS, 32, output rows per tile
- SUBARRAY_COLS, 8, K elements per tile
- INPUT_WIDTH, 8, input element bits
- WEIGHT_WIDTH, 8, weight element bits
- OUTPUT_WIDTH, 32, accumulator bits
- BUF_DEPTH, 4, BRAM depth (only address 0 used)
- KT_WIDTH, 16, width of the K-tile count

Ports:
- clk  in  1  single clock; all logic posedge
- rst  in  1  asynchronous, active-high reset
- cmd_valid / cmd_ready  in / out  1 / 1  job command handshake
- cmd_k_tiles  in  KT_WIDTH  number of K-tiles in the job
- tile_valid / tile_ready  in / out  1 / 1  tile handshake
- tile_weight  in  ROWS*COLS*WEIGHT_WIDTH  weight tile, element [r][c] at bit (r*COLS+c)*WEIGHT_WIDTH
- tile_input  in  COLS*INPUT_WIDTH  input slice, element c at bit c*INPUT_WIDTH
- wbuf_addr, wbuf_wr_en, wbuf_wdata  out  clog2(BUF_DEPTH), 1, weight width  weight BRAM Port A
- ibuf_addr, ibuf_wr_en, ibuf_wdata  out  clog2(BUF_DEPTH), 1, input width  input BRAM Port A
- obuf_addr, obuf_rd_en  out  clog2(BUF_DEPTH), 1  output BRAM Port B
- obuf_rdata  in  ROWS*OUTPUT_WIDTH  output BRAM read data
- pe_start, pe_clear_acc  out  1  to the PE controller
- pe_busy, pe_done  in  1  from the PE controller
- res_valid / res_ready  out / in  1 / 1  result handshake
- res_data  out  ROWS*OUTPUT_WIDTH  accumulated output vector
- job_busy, job_done  out  1  status; `job_done` is a 1-cycle pulse
- perf_busy_cycles, perf_stall_cycles  out  32 each  performance counters (see Configuration)

## Operation
- States: S_IDLE, S_FETCH, S_KICK, S_PE_WAIT, S_ORD, S_ORD_WAIT, S_OCAP, S_OUT, S_DONE.
- S_IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch `tiles_left`=`cmd_k_tiles` and set `first`=1.
  - If `cmd_k_tiles`==0, go to S_DONE. Otherwise go to S_FETCH.
- S_FETCH:
  - `tile_ready`=1.
  - `wbuf_wr_en` and `ibuf_wr_en` = `tile_valid`. Write data is passed through combinationally from `tile_weight` / `tile_input`.
  - On handshake, go to S_KICK.
- S_KICK:
  - `pe_start`=1 for exactly 1 cycle; `pe_clear_acc`=`first`.
  - Clear `first`, decrement `tiles_left`, go to S_PE_WAIT.
- S_PE_WAIT:
  - On `pe_done`: go to S_FETCH if `tiles_left`!=0, else go to S_ORD.
- S_ORD: `obuf_rd_en`=1.
- S_ORD_WAIT: BRAM output-register cycle.
- S_OCAP: `res_data` <= `obuf_rdata`.
- S_OUT:
  - `res_valid`=1.
  - On `res_ready`, go to S_DONE.
- S_DONE: `job_done`=1, then go to S_IDLE.
- All addresses are constant 0.
- `job_busy` = (state != S_IDLE).
- `cmd_ready`=0 whenever not in S_IDLE. Commands presented while busy are not consumed.
- `tile_ready`=0 outside S_FETCH.
- `pe_busy` is informational only. `pe_done` is only acted on in S_PE_WAIT and is ignored in every other state.
- `tiles_left` is never decremented below 0.

## Timing
- Reset value of all outputs is 0, except `cmd_ready`=1 (state S_IDLE). `res_data` resets to 0.
- Reset mid-job: return to S_IDLE immediately. No result and no `job_done` are produced. The PE controller is reset separately.
- Command accept at cycle c:
  - First `tile_ready` at c+1.
  - BRAM write happens in the tile handshake cycle t.
  - `pe_start` at t+1.
- Per tile: 1 fetch cycle (plus input stall) + 1 kick cycle + PE latency + 1 cycle back to S_FETCH.
- After the last `pe_done` at cycle d:
  - `obuf_rd_en` at d+1.
  - Data is sampled at d+3.
  - `res_valid` is first asserted at d+4.
- `res_data` is stable while `res_valid` is high and `res_ready` is low.
- `job_done` is asserted the cycle after the result handshake.
- k=0 job: accept at c, `job_done` at c+1, back in S_IDLE at c+2.

## Configuration
- `GEMV_SEQ_PERF_EN` defined:
  - `perf_busy_cycles` counts cycles with `job_busy`=1.
  - `perf_stall_cycles` counts cycles in S_FETCH with `tile_valid`=0, plus cycles in S_OUT with `res_ready`=0.
  - Both counters clear when a command is accepted, saturate at all-ones, and hold their value after the job completes.
- `GEMV_SEQ_PERF_EN` undefined: both counter ports are tied to 0 and no counter flops are built.

## Structure
- Shared package `gemv_pkg` holds:
  - the `seq_state_t` enum;
  - default geometry localparams (ROWS/COLS/widths);
  - the packed-layout index helper functions.
- Performance counters live in one sub-module, `gemv_seq_perf`, instantiated only under `GEMV_SEQ_PERF_EN`.

## Test plan
Benches instantiate the sequencer with the PE controller, `gemv_subarray`, and 2-cycle BRAMs.
- k=1, all weights=1, all inputs=2 -> every `res_data` row = 16; exactly one `pe_start`, with `pe_clear_acc`=1.
- k=3, weights=1, inputs=1 each tile -> rows = 24; `pe_clear_acc` is 1 only on the first of 3 `pe_start` pulses.
- Back-to-back jobs (k=2 with weights=3, inputs=1; then k=1 with weights=1, inputs=1) -> rows 48, then 8, with no carryover between jobs.
- Hold `res_ready`=0 for 10 cycles -> `res_data` stable, no `job_done` until the handshake, `cmd_ready`=0 throughout.
- k=0 -> `job_done` 1 cycle after accept; no `tile_ready`, `pe_start`, or `res_valid`.
- Assert `rst` during S_PE_WAIT of a k=2 job -> all outputs 0 and `cmd_ready`=1 the same cycle; a following k=1 job with weights=1, inputs=2 completes with rows = 16.

Source files
------------

// File: rtl/gemv_pkg.sv
// Shared types, default geometry and packed-layout helpers for the GEMV tile sequencer.
package gemv_pkg;

  localparam int GEMV_ROWS      = 32;
  localparam int GEMV_COLS      = 8;
  localparam int GEMV_IN_W      = 8;
  localparam int GEMV_WT_W      = 8;
  localparam int GEMV_OUT_W     = 32;
  localparam int GEMV_BUF_DEPTH = 4;
  localparam int GEMV_KT_W      = 16;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_KICK     = 4'd2,
    S_PE_WAIT  = 4'd3,
    S_ORD      = 4'd4,
    S_ORD_WAIT = 4'd5,
    S_OCAP     = 4'd6,
    S_OUT      = 4'd7,
    S_DONE     = 4'd8
  } seq_state_t;

  // Weight element [r][c] lives at bit (r*cols+c)*w of the packed tile.
  function automatic int weight_lsb(input int r, input int c, input int cols, input int w);
    return (r * cols + c) * w;
  endfunction

  function automatic int input_lsb(input int c, input int w);
    return c * w;
  endfunction

  function automatic int output_lsb(input int r, input int w);
    return r * w;
  endfunction

endpackage

// File: rtl/gemv_seq_perf.sv
// Saturating busy/stall cycle counters for the tile sequencer, cleared on job accept.
module gemv_seq_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             busy,
  input  logic             stall,
  output logic [CNT_W-1:0] busy_cycles,
  output logic [CNT_W-1:0] stall_cycles
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Counters hold after the job so software can read them at leisure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cycles  <= {CNT_W{1'b0}};
      stall_cycles <= {CNT_W{1'b0}};
    end else if (clear) begin
      busy_cycles  <= {CNT_W{1'b0}};
      stall_cycles <= {CNT_W{1'b0}};
    end else begin
      if (busy) begin
        busy_cycles <= sat_inc(busy_cycles);
      end
      if (stall) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
    end
  end

endmodule

// File: rtl/gemv_tile_seq.sv
// K-tiling sequencer: loads tiles into the PE buffers, runs the PE per tile, returns the result.
// Optional performance counters are built when GEMV_SEQ_PERF_EN is defined.
module gemv_tile_seq
  import gemv_pkg::*;
#(
  parameter int SUBARRAY_ROWS = GEMV_ROWS,
  parameter int SUBARRAY_COLS = GEMV_COLS,
  parameter int INPUT_WIDTH   = GEMV_IN_W,
  parameter int WEIGHT_WIDTH  = GEMV_WT_W,
  parameter int OUTPUT_WIDTH  = GEMV_OUT_W,
  parameter int BUF_DEPTH     = GEMV_BUF_DEPTH,
  parameter int KT_WIDTH      = GEMV_KT_W,
  localparam int ADDR_W = $clog2(BUF_DEPTH),
  localparam int WT_W   = SUBARRAY_ROWS * SUBARRAY_COLS * WEIGHT_WIDTH,
  localparam int IN_W   = SUBARRAY_COLS * INPUT_WIDTH,
  localparam int RES_W  = SUBARRAY_ROWS * OUTPUT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [KT_WIDTH-1:0] cmd_k_tiles,
  input  logic                tile_valid,
  output logic                tile_ready,
  input  logic [WT_W-1:0]     tile_weight,
  input  logic [IN_W-1:0]     tile_input,
  output logic [ADDR_W-1:0]   wbuf_addr,
  output logic                wbuf_wr_en,
  output logic [WT_W-1:0]     wbuf_wdata,
  output logic [ADDR_W-1:0]   ibuf_addr,
  output logic                ibuf_wr_en,
  output logic [IN_W-1:0]     ibuf_wdata,
  output logic [ADDR_W-1:0]   obuf_addr,
  output logic                obuf_rd_en,
  input  logic [RES_W-1:0]    obuf_rdata,
  output logic                pe_start,
  output logic                pe_clear_acc,
  input  logic                pe_busy,
  input  logic                pe_done,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [RES_W-1:0]    res_data,
  output logic                job_busy,
  output logic                job_done,
  output logic [31:0]         perf_busy_cycles,
  output logic [31:0]         perf_stall_cycles
);

  seq_state_t          state_r;
  logic [KT_WIDTH-1:0] tiles_left_r;
  logic                first_r;
  logic                cmd_ready_r;
  logic                tile_ready_r;
  logic                pe_start_r;
  logic                pe_clear_acc_r;
  logic                obuf_rd_en_r;
  logic                res_valid_r;
  logic [RES_W-1:0]    res_data_r;
  logic                job_busy_r;
  logic                job_done_r;
  logic                unused_s;

  // PE progress is tracked purely through pe_done.
  assign unused_s = pe_busy;

  // Sequencer FSM; every output is set for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= S_IDLE;
      tiles_left_r   <= {KT_WIDTH{1'b0}};
      first_r        <= 1'b0;
      cmd_ready_r    <= 1'b1;
      tile_ready_r   <= 1'b0;
      pe_start_r     <= 1'b0;
      pe_clear_acc_r <= 1'b0;
      obuf_rd_en_r   <= 1'b0;
      res_valid_r    <= 1'b0;
      res_data_r     <= {RES_W{1'b0}};
      job_busy_r     <= 1'b0;
      job_done_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (cmd_valid) begin
            tiles_left_r <= cmd_k_tiles;
            first_r      <= 1'b1;
            cmd_ready_r  <= 1'b0;
            job_busy_r   <= 1'b1;
            if (cmd_k_tiles == {KT_WIDTH{1'b0}}) begin
              state_r    <= S_DONE;
              job_done_r <= 1'b1;
            end else begin
              state_r      <= S_FETCH;
              tile_ready_r <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (tile_valid) begin
            state_r        <= S_KICK;
            tile_ready_r   <= 1'b0;
            pe_start_r     <= 1'b1;
            pe_clear_acc_r <= first_r;
          end
        end
        S_KICK: begin
          state_r        <= S_PE_WAIT;
          pe_start_r     <= 1'b0;
          pe_clear_acc_r <= 1'b0;
          first_r        <= 1'b0;
          if (tiles_left_r != {KT_WIDTH{1'b0}}) begin
            tiles_left_r <= tiles_left_r - {{(KT_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        S_PE_WAIT: begin
          if (pe_done) begin
            if (tiles_left_r != {KT_WIDTH{1'b0}}) begin
              state_r      <= S_FETCH;
              tile_ready_r <= 1'b1;
            end else begin
              state_r      <= S_ORD;
              obuf_rd_en_r <= 1'b1;
            end
          end
        end
        S_ORD: begin
          state_r      <= S_ORD_WAIT;
          obuf_rd_en_r <= 1'b0;
        end
        S_ORD_WAIT: begin
          state_r <= S_OCAP;
        end
        S_OCAP: begin
          state_r     <= S_OUT;
          res_data_r  <= obuf_rdata;
          res_valid_r <= 1'b1;
        end
        S_OUT: begin
          if (res_ready) begin
            state_r     <= S_DONE;
            res_valid_r <= 1'b0;
            job_done_r  <= 1'b1;
          end
        end
        S_DONE: begin
          state_r     <= S_IDLE;
          job_done_r  <= 1'b0;
          job_busy_r  <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
        default: begin
          state_r        <= S_IDLE;
          tile_ready_r   <= 1'b0;
          pe_start_r     <= 1'b0;
          pe_clear_acc_r <= 1'b0;
          obuf_rd_en_r   <= 1'b0;
          res_valid_r    <= 1'b0;
          job_busy_r     <= 1'b0;
          job_done_r     <= 1'b0;
          cmd_ready_r    <= 1'b1;
        end
      endcase
    end
  end

  // Tile data goes straight into Port A so the write lands in the handshake cycle.
  assign wbuf_addr    = {ADDR_W{1'b0}};
  assign ibuf_addr    = {ADDR_W{1'b0}};
  assign obuf_addr    = {ADDR_W{1'b0}};
  assign wbuf_wr_en   = tile_ready_r & tile_valid;
  assign ibuf_wr_en   = tile_ready_r & tile_valid;
  assign wbuf_wdata   = tile_weight;
  assign ibuf_wdata   = tile_input;
  assign cmd_ready    = cmd_ready_r;
  assign tile_ready   = tile_ready_r;
  assign pe_start     = pe_start_r;
  assign pe_clear_acc = pe_clear_acc_r;
  assign obuf_rd_en   = obuf_rd_en_r;
  assign res_valid    = res_valid_r;
  assign res_data     = res_data_r;
  assign job_busy     = job_busy_r;
  assign job_done     = job_done_r;

`ifdef GEMV_SEQ_PERF_EN
  logic cmd_accept_s;
  logic stall_s;

  assign cmd_accept_s = cmd_ready_r & cmd_valid;
  assign stall_s      = ((state_r == S_FETCH) & ~tile_valid) | ((state_r == S_OUT) & ~res_ready);

  gemv_seq_perf #(
    .CNT_W(32)
  ) u_perf (
    .clk          (clk),
    .rst          (rst),
    .clear        (cmd_accept_s),
    .busy         (job_busy_r),
    .stall        (stall_s),
    .busy_cycles  (perf_busy_cycles),
    .stall_cycles (perf_stall_cycles)
  );
`else
  assign perf_busy_cycles  = 32'd0;
  assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_gemv_tile_seq.sv
// Directed bench for gemv_tile_seq with behavioural weight/input/output BRAMs and a PE model.
module tb_gemv_tile_seq;
  import gemv_pkg::*;

  localparam int ROWS   = 32;
  localparam int COLS   = 8;
  localparam int IW     = 8;
  localparam int WW     = 8;
  localparam int OW     = 32;
  localparam int AW     = 2;
  localparam int PE_LAT = 4;
  localparam int WT_W   = ROWS * COLS * WW;
  localparam int IN_W   = COLS * IW;
  localparam int RES_W  = ROWS * OW;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [15:0]      cmd_k_tiles;
  logic             tile_valid;
  logic             tile_ready;
  logic [WT_W-1:0]  tile_weight;
  logic [IN_W-1:0]  tile_input;
  logic [AW-1:0]    wbuf_addr;
  logic             wbuf_wr_en;
  logic [WT_W-1:0]  wbuf_wdata;
  logic [AW-1:0]    ibuf_addr;
  logic             ibuf_wr_en;
  logic [IN_W-1:0]  ibuf_wdata;
  logic [AW-1:0]    obuf_addr;
  logic             obuf_rd_en;
  logic [RES_W-1:0] obuf_rdata;
  logic             pe_start;
  logic             pe_clear_acc;
  logic             pe_busy;
  logic             pe_done;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;
  logic             job_busy;
  logic             job_done;
  logic [31:0]      perf_busy_cycles;
  logic [31:0]      perf_stall_cycles;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  gemv_tile_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k_tiles(cmd_k_tiles),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_weight(tile_weight), .tile_input(tile_input),
    .wbuf_addr(wbuf_addr), .wbuf_wr_en(wbuf_wr_en), .wbuf_wdata(wbuf_wdata),
    .ibuf_addr(ibuf_addr), .ibuf_wr_en(ibuf_wr_en), .ibuf_wdata(ibuf_wdata),
    .obuf_addr(obuf_addr), .obuf_rd_en(obuf_rd_en), .obuf_rdata(obuf_rdata),
    .pe_start(pe_start), .pe_clear_acc(pe_clear_acc),
    .pe_busy(pe_busy), .pe_done(pe_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .job_busy(job_busy), .job_done(job_done),
    .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles)
  );

  // Behavioural buffers and PE
  logic [WT_W-1:0]  wmem;
  logic [IN_W-1:0]  imem;
  logic [RES_W-1:0] omem;
  logic [RES_W-1:0] orq1;
  logic             pe_run;
  logic             pe_clr;
  int               pe_cnt;

  function automatic logic [RES_W-1:0] pe_compute(input logic [WT_W-1:0] w, input logic [IN_W-1:0] x,
                                                  input logic [RES_W-1:0] acc, input logic clr);
    logic [RES_W-1:0] res;
    logic [OW-1:0]    s;
    res = '0;
    for (int r = 0; r < ROWS; r++) begin
      s = clr ? 32'd0 : acc[output_lsb(r, OW) +: OW];
      for (int c = 0; c < COLS; c++) begin
        s = s + 32'(w[weight_lsb(r, c, COLS, WW) +: WW]) * 32'(x[input_lsb(c, IW) +: IW]);
      end
      res[output_lsb(r, OW) +: OW] = s;
    end
    return res;
  endfunction

  assign pe_busy = pe_run;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_run     <= 1'b0;
      pe_done    <= 1'b0;
      pe_cnt     <= 0;
      pe_clr     <= 1'b0;
      orq1       <= '0;
      obuf_rdata <= '0;
    end else begin
      if (wbuf_wr_en) wmem <= wbuf_wdata;
      if (ibuf_wr_en) imem <= ibuf_wdata;
      if (obuf_rd_en) orq1 <= omem;
      obuf_rdata <= orq1;
      pe_done    <= 1'b0;
      if (pe_start) begin
        pe_run <= 1'b1;
        pe_cnt <= PE_LAT;
        pe_clr <= pe_clear_acc;
      end else if (pe_run) begin
        if (pe_cnt == 1) begin
          pe_run  <= 1'b0;
          pe_done <= 1'b1;
          omem    <= pe_compute(wmem, imem, omem, pe_clr);
        end else begin
          pe_cnt <= pe_cnt - 1;
        end
      end
    end
  end

  // Event counters
  int n_start = 0, n_clr = 0, n_tr = 0, n_rv = 0, n_done = 0;
  always @(posedge clk) begin
    if (pe_start) n_start++;
    if (pe_start && pe_clear_acc) n_clr++;
    if (tile_ready) n_tr++;
    if (res_valid) n_rv++;
    if (job_done) n_done++;
  end

  task automatic set_tile(input logic [7:0] wv, input logic [7:0] xv);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        tile_weight[weight_lsb(r, c, COLS, WW) +: WW] = wv;
    for (int c = 0; c < COLS; c++) tile_input[input_lsb(c, IW) +: IW] = xv;
  endtask

  task automatic do_cmd(input logic [15:0] k, output bit to);
    to = 1'b1;
    cmd_valid = 1'b1;
    cmd_k_tiles = k;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready) begin
        @(negedge clk);
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic do_tile(output bit to);
    to = 1'b1;
    tile_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (tile_ready) begin
        @(negedge clk);
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    tile_valid = 1'b0;
  endtask

  task automatic wait_res(output int cyc, output bit to);
    to = 1'b1;
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      if (res_valid) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_k_tiles = 16'd0; tile_valid = 1'b0; res_ready = 1'b0;
    tile_weight = '0; tile_input = '0;
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({cmd_ready, tile_ready, pe_start, pe_clear_acc, obuf_rd_en, res_valid, job_busy, job_done} !== 8'b1000_0000)
      $display("FAIL rst_ctrl: got %b want 10000000",
               {cmd_ready, tile_ready, pe_start, pe_clear_acc, obuf_rd_en, res_valid, job_busy, job_done});
    else pass_cnt++;
    check_cnt++;
    if (res_data !== '0) $display("FAIL rst_res_data: got %h want 0", res_data[31:0]); else pass_cnt++;
    check_cnt++;
    if ({perf_busy_cycles, perf_stall_cycles} !== 64'd0) $display("FAIL rst_perf: got %0d/%0d want 0/0",
        perf_busy_cycles, perf_stall_cycles); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    check_cnt++;
    if ({cmd_ready, job_busy} !== 2'b10) $display("FAIL post_rst_idle: got %b want 10", {cmd_ready, job_busy});
    else pass_cnt++;
  endtask

  task automatic check_rows(input string name, input logic [31:0] exp);
    for (int r = 0; r < ROWS; r++) begin
      check_cnt++;
      if (res_data[output_lsb(r, OW) +: OW] !== exp)
        $display("FAIL %s row %0d: got %0d want %0d", name, r, res_data[output_lsb(r, OW) +: OW], exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_k1;
    bit to; int cyc; int s0, c0;
    s0 = n_start; c0 = n_clr;
    set_tile(8'd1, 8'd2);
    do_cmd(16'd1, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL k1_cmd_timeout: got 1 want 0"); else pass_cnt++;
    check_cnt++; if (tile_ready !== 1'b1) $display("FAIL k1_first_tile_ready: got %b want 1", tile_ready); else pass_cnt++;
    do_tile(to);
    check_cnt++; if (to !== 1'b0) $display("FAIL k1_tile_timeout: got 1 want 0"); else pass_cnt++;
    check_cnt++;
    if ({pe_start, pe_clear_acc} !== 2'b11) $display("FAIL k1_kick: got %b want 11", {pe_start, pe_clear_acc});
    else pass_cnt++;
    wait_res(cyc, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL k1_res_timeout: got 1 want 0"); else pass_cnt++;
    check_cnt++; if (cyc !== 9) $display("FAIL k1_res_latency: got %0d want 9", cyc); else pass_cnt++;
    check_rows("k1_rows", 32'd16);
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    check_cnt++; if (job_done !== 1'b1) $display("FAIL k1_job_done: got %b want 1", job_done); else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({job_done, cmd_ready, job_busy} !== 3'b010) $display("FAIL k1_back_idle: got %b want 010",
        {job_done, cmd_ready, job_busy}); else pass_cnt++;
    check_cnt++; if (n_start - s0 !== 1) $display("FAIL k1_start_cnt: got %0d want 1", n_start - s0); else pass_cnt++;
    check_cnt++; if (n_clr - c0 !== 1) $display("FAIL k1_clr_cnt: got %0d want 1", n_clr - c0); else pass_cnt++;
  endtask

  task automatic test_k3;
    bit to; int cyc; int s0, c0;
    s0 = n_start; c0 = n_clr;
    set_tile(8'd1, 8'd1);
    do_cmd(16'd3, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL k3_cmd_timeout: got 1 want 0"); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      do_tile(to);
      check_cnt++; if (to !== 1'b0) $display("FAIL k3_tile_timeout %0d: got 1 want 0", i); else pass_cnt++;
    end
    wait_res(cyc, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL k3_res_timeout: got 1 want 0"); else pass_cnt++;
    check_rows("k3_rows", 32'd24);
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    @(negedge clk);
    check_cnt++; if (n_start - s0 !== 3) $display("FAIL k3_start_cnt: got %0d want 3", n_start - s0); else pass_cnt++;
    check_cnt++; if (n_clr - c0 !== 1) $display("FAIL k3_clr_cnt: got %0d want 1", n_clr - c0); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    bit to; int cyc;
    set_tile(8'd3, 8'd1);
    do_cmd(16'd2, to);
    do_tile(to);
    do_tile(to);
    wait_res(cyc, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL b2b_res1_timeout: got 1 want 0"); else pass_cnt++;
    check_rows("b2b_rows1", 32'd48);
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    set_tile(8'd1, 8'd1);
    do_cmd(16'd1, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL b2b_cmd2_timeout: got 1 want 0"); else pass_cnt++;
    do_tile(to);
    wait_res(cyc, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL b2b_res2_timeout: got 1 want 0"); else pass_cnt++;
    check_rows("b2b_rows2", 32'd8);
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit to; int cyc; int d0; logic [RES_W-1:0] snap;
    set_tile(8'd1, 8'd1);
    do_cmd(16'd1, to);
    do_tile(to);
    wait_res(cyc, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL bp_res_timeout: got 1 want 0"); else pass_cnt++;
    snap = res_data;
    d0 = n_done;
    cmd_valid = 1'b1; cmd_k_tiles = 16'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_cnt++;
      if ({res_valid, job_done, cmd_ready} !== 3'b100 || res_data !== snap)
        $display("FAIL bp_hold cycle %0d: got v/d/cr=%b row0=%0d want 100 row0=%0d",
                 i, {res_valid, job_done, cmd_ready}, res_data[31:0], snap[31:0]);
      else pass_cnt++;
    end
    cmd_valid = 1'b0;
    check_cnt++; if (n_done - d0 !== 0) $display("FAIL bp_no_done: got %0d want 0", n_done - d0); else pass_cnt++;
    check_rows("bp_rows", 32'd8);
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    check_cnt++; if (job_done !== 1'b1) $display("FAIL bp_job_done: got %b want 1", job_done); else pass_cnt++;
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({job_busy, tile_ready} !== 2'b00) $display("FAIL bp_busy_cmd_dropped: got %b want 00", {job_busy, tile_ready});
    else pass_cnt++;
  endtask

  task automatic test_k0;
    bit to; int t0, s0, v0;
    t0 = n_tr; s0 = n_start; v0 = n_rv;
    do_cmd(16'd0, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL k0_cmd_timeout: got 1 want 0"); else pass_cnt++;
    check_cnt++;
    if ({job_done, job_busy, cmd_ready} !== 3'b110) $display("FAIL k0_done_pulse: got %b want 110",
        {job_done, job_busy, cmd_ready}); else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({job_done, job_busy, cmd_ready} !== 3'b001) $display("FAIL k0_idle: got %b want 001",
        {job_done, job_busy, cmd_ready}); else pass_cnt++;
    check_cnt++;
    if ((n_tr - t0) + (n_start - s0) + (n_rv - v0) !== 0)
      $display("FAIL k0_no_activity: got %0d want 0", (n_tr - t0) + (n_start - s0) + (n_rv - v0));
    else pass_cnt++;
    check_cnt++;
`ifdef GEMV_SEQ_PERF_EN
    if ({perf_busy_cycles, perf_stall_cycles} !== {32'd1, 32'd0})
      $display("FAIL k0_perf: got %0d/%0d want 1/0", perf_busy_cycles, perf_stall_cycles);
    else pass_cnt++;
`else
    if ({perf_busy_cycles, perf_stall_cycles} !== 64'd0)
      $display("FAIL k0_perf: got %0d/%0d want 0/0", perf_busy_cycles, perf_stall_cycles);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid_job;
    bit to; int cyc; int d0, v0;
    set_tile(8'd1, 8'd1);
    do_cmd(16'd2, to);
    do_tile(to);
    @(negedge clk);
    check_cnt++; if (pe_busy !== 1'b1) $display("FAIL rmj_pe_running: got %b want 1", pe_busy); else pass_cnt++;
    d0 = n_done; v0 = n_rv;
    rst = 1'b1;
    #1;
    check_cnt++;
    if ({cmd_ready, tile_ready, pe_start, pe_clear_acc, obuf_rd_en, res_valid, job_busy, job_done} !== 8'b1000_0000)
      $display("FAIL rmj_outputs: got %b want 10000000",
               {cmd_ready, tile_ready, pe_start, pe_clear_acc, obuf_rd_en, res_valid, job_busy, job_done});
    else pass_cnt++;
    check_cnt++; if (res_data !== '0) $display("FAIL rmj_res_data: got %0d want 0", res_data[31:0]); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check_cnt++;
    if ((n_done - d0) + (n_rv - v0) !== 0) $display("FAIL rmj_no_result: got %0d want 0", (n_done - d0) + (n_rv - v0));
    else pass_cnt++;
    set_tile(8'd1, 8'd2);
    do_cmd(16'd1, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL rmj_cmd_timeout: got 1 want 0"); else pass_cnt++;
    do_tile(to);
    wait_res(cyc, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL rmj_res_timeout: got 1 want 0"); else pass_cnt++;
    check_rows("rmj_rows", 32'd16);
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    check_cnt++; if (job_done !== 1'b1) $display("FAIL rmj_job_done: got %b want 1", job_done); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_k1();
    test_k3();
    test_back_to_back();
    test_backpressure();
    test_k0();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
